// File: rtl/noc_pkg.sv
// Shared NoC definitions for the router_wrap tile and its user-fabric
// endpoints.
//   NOC_DATA_W / NOC_DEST_W : default flit payload and destination widths
//   flit_t                  : flit at the default widths
//   frame_state_e           : input-side packet framing state
package noc_pkg;

  localparam int NOC_DATA_W = 32;
  localparam int NOC_DEST_W = 6;

  typedef struct packed {
    logic [NOC_DATA_W-1:0] data;
    logic [NOC_DEST_W-1:0] dest;
    logic                  is_tail;
  } flit_t;

  typedef enum logic {
    FR_HEAD = 1'b0,
    FR_BODY = 1'b1
  } frame_state_e;

endpackage

// File: rtl/noc_flit_fifo.sv
// Show-ahead synchronous FIFO for flits.
//   clk, rst_n : clock, async active-low reset
//   push/wdata : write one entry (caller guarantees room, or a same-cycle pop)
//   pop        : drop head entry (caller guarantees non-empty)
//   rdata      : head entry, zero while empty
//   full/count : occupancy status
module noc_flit_fifo #(
  parameter int W     = 39,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          empty;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  // Head is masked while empty so the stream outputs read zero after reset.
  assign rdata = empty ? '0 : mem[rd_ptr];

  // Storage needs no reset; only pointers/count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/noc_port_rx.sv
// Receive endpoint for one router output link. Buffers credit-flow flits in
// a DEPTH-entry FIFO, returns one credit per drained flit and presents the
// flits as an AXI-stream master.
//   send_in/data_in/dest_in/is_tail_in : flit from router port, no backpressure
//   credit_out                         : registered one-cycle credit pulse
//   m_t*                               : AXI-stream master (show-ahead head)
//   overflow_err / framing_err         : sticky error flags
//   pkt_count                          : delivered packets, 16-bit wrap
module noc_port_rx
  import noc_pkg::*;
#(
  parameter int DATA_W = NOC_DATA_W,
  parameter int DEST_W = NOC_DEST_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk_noc,
  input  logic              rst_n,
  input  logic              send_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DEST_W-1:0] dest_in,
  input  logic              is_tail_in,
  output logic              credit_out,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic [DEST_W-1:0] m_tdest,
  output logic              m_tlast,
  output logic              overflow_err,
  output logic              framing_err,
  output logic [15:0]       pkt_count
);

  localparam int FW = DATA_W + DEST_W + 1;
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [DEST_W-1:0] dest;
    logic              is_tail;
  } rx_flit_t;

  rx_flit_t     wflit, hflit;
  logic         full, pop, accept;
  logic [AW:0]  occupancy;

  assign wflit  = '{data: data_in, dest: dest_in, is_tail: is_tail_in};
  assign pop    = m_tvalid & m_tready;
  // A full buffer still takes a flit when the head leaves in the same cycle.
  assign accept = send_in & (~full | pop);

  noc_flit_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk_noc),
    .rst_n (rst_n),
    .push  (accept),
    .wdata (wflit),
    .pop   (pop),
    .rdata (hflit),
    .full  (full),
    .count (occupancy)
  );

  assign m_tvalid = (occupancy != '0);
  assign m_tdata  = hflit.data;
  assign m_tdest  = hflit.dest;
  assign m_tlast  = hflit.is_tail;

  // Framing FSM: dropped flits never advance it.
  frame_state_e      state_q, state_d;
  logic [DEST_W-1:0] dest_q, dest_d;
  logic              frame_bad;

  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FR_HEAD;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dest_d    = dest_q;
    frame_bad = 1'b0;
    case (state_q)
      FR_HEAD: begin
        if (accept && !is_tail_in) begin
          dest_d  = dest_in;
          state_d = FR_BODY;
        end
      end
      FR_BODY: begin
        if (accept) begin
          frame_bad = (dest_in != dest_q);
          if (is_tail_in) state_d = FR_HEAD;
        end
      end
      default: state_d = FR_HEAD;
    endcase
  end

  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      credit_out   <= 1'b0;
      overflow_err <= 1'b0;
      framing_err  <= 1'b0;
      pkt_count    <= '0;
    end else begin
      credit_out <= pop;
      if (send_in && !accept) overflow_err <= 1'b1;
      if (frame_bad)          framing_err  <= 1'b1;
      if (pop && m_tlast)     pkt_count    <= pkt_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_noc_port_rx.sv
// Self-checking bench for noc_port_rx: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_noc_port_rx;
  import noc_pkg::*;

  localparam int DEPTH = 4;

  logic        clk_noc = 1'b0;
  logic        rst_n;
  logic        send_in, is_tail_in, m_tready;
  logic [31:0] data_in;
  logic [5:0]  dest_in;
  logic        credit_out, m_tvalid, m_tlast, overflow_err, framing_err;
  logic [31:0] m_tdata;
  logic [5:0]  m_tdest;
  logic [15:0] pkt_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  flit_t       mq[$];
  logic        exp_credit, exp_ovf, exp_ferr, in_pkt;
  logic [15:0] exp_pkt;
  logic [5:0]  pkt_dest;

  noc_port_rx #(.DATA_W(32), .DEST_W(6), .DEPTH(DEPTH)) dut (
    .clk_noc      (clk_noc),
    .rst_n        (rst_n),
    .send_in      (send_in),
    .data_in      (data_in),
    .dest_in      (dest_in),
    .is_tail_in   (is_tail_in),
    .credit_out   (credit_out),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tdata      (m_tdata),
    .m_tdest      (m_tdest),
    .m_tlast      (m_tlast),
    .overflow_err (overflow_err),
    .framing_err  (framing_err),
    .pkt_count    (pkt_count)
  );

  always #5 clk_noc = ~clk_noc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_credit = 1'b0;
    exp_ovf    = 1'b0;
    exp_ferr   = 1'b0;
    exp_pkt    = '0;
    in_pkt     = 1'b0;
    pkt_dest   = '0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_credit"}, 64'(credit_out), 64'd0);
    chk({tag, "_tvalid"}, 64'(m_tvalid), 64'd0);
    chk({tag, "_tdata"},  64'(m_tdata), 64'd0);
    chk({tag, "_tdest"},  64'(m_tdest), 64'd0);
    chk({tag, "_tlast"},  64'(m_tlast), 64'd0);
    chk({tag, "_ovf"},    64'(overflow_err), 64'd0);
    chk({tag, "_ferr"},   64'(framing_err), 64'd0);
    chk({tag, "_pkt"},    64'(pkt_count), 64'd0);
    chk({tag, "_occ"},    64'(dut.occupancy), 64'd0);
  endtask

  task automatic check_outputs();
    chk("tvalid", 64'(m_tvalid), 64'(mq.size() > 0));
    chk("credit", 64'(credit_out), 64'(exp_credit));
    chk("overflow_err", 64'(overflow_err), 64'(exp_ovf));
    chk("framing_err", 64'(framing_err), 64'(exp_ferr));
    chk("pkt_count", 64'(pkt_count), 64'(exp_pkt));
    chk("occupancy", 64'(dut.occupancy), 64'(mq.size()));
    if (mq.size() > 0) begin
      chk("tdata", 64'(m_tdata), 64'(mq[0].data));
      chk("tdest", 64'(m_tdest), 64'(mq[0].dest));
      chk("tlast", 64'(m_tlast), 64'(mq[0].is_tail));
    end
  endtask

  // One clock cycle: drive inputs, check pre-edge outputs on the falling
  // edge, then advance the model by the rules of push/pop/credit/framing.
  task automatic cyc(input logic s, input logic [31:0] d, input logic [5:0] ds,
                     input logic t, input logic r);
    flit_t head;
    logic  pop, acc;
    send_in = s; data_in = d; dest_in = ds; is_tail_in = t; m_tready = r;
    @(negedge clk_noc);
    check_outputs();
    pop = (mq.size() > 0) && r;
    acc = s && ((mq.size() < DEPTH) || pop);
    if (pop) begin
      head = mq.pop_front();
      if (head.is_tail) exp_pkt = exp_pkt + 16'd1;
    end
    if (acc) begin
      mq.push_back(flit_t'{data: d, dest: ds, is_tail: t});
      if (in_pkt && ds != pkt_dest) exp_ferr = 1'b1;
      if (!in_pkt && !t) begin
        in_pkt   = 1'b1;
        pkt_dest = ds;
      end else if (in_pkt && t) begin
        in_pkt = 1'b0;
      end
    end
    if (s && !acc) exp_ovf = 1'b1;
    exp_credit = pop;
    @(posedge clk_noc); #1;
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 6'h0, 1'b0, r);
  endtask

  initial begin
    logic [5:0] rdest;
    rst_n = 1'b0; send_in = 1'b0; data_in = '0; dest_in = '0;
    is_tail_in = 1'b0; m_tready = 1'b0;
    model_reset();
    #3;
    check_reset_values("reset");
    repeat (2) @(posedge clk_noc);
    @(negedge clk_noc) rst_n = 1'b1;
    @(posedge clk_noc); #1;

    // Single flit, ready held high
    cyc(1'b1, 32'hDEADBEEF, 6'h05, 1'b1, 1'b1);
    chk("single_tvalid", 64'(m_tvalid), 64'd1);
    chk("single_tdata", 64'(m_tdata), 64'hDEADBEEF);
    idle(3, 1'b1);
    chk("single_pkt", 64'(pkt_count), 64'd1);

    // Full buffer with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 32'h100 + 32'(i), 6'h07, 1'b1, 1'b0);
    cyc(1'b1, 32'h1FF, 6'h07, 1'b1, 1'b1);
    chk("simul_occ", 64'(dut.occupancy), 64'(DEPTH));
    chk("simul_ovf", 64'(overflow_err), 64'd0);
    idle(DEPTH + 2, 1'b1);

    // Fill, overflow on the 5th flit, then drain in order
    for (int i = 0; i <= DEPTH; i++) cyc(1'b1, 32'h200 + 32'(i), 6'h09, 1'b1, 1'b0);
    chk("fill_ovf", 64'(overflow_err), 64'd1);
    chk("fill_occ", 64'(dut.occupancy), 64'(DEPTH));
    idle(DEPTH + 2, 1'b1);

    // Framing error inside a 3-flit packet
    cyc(1'b1, 32'hA0, 6'h02, 1'b0, 1'b1);
    cyc(1'b1, 32'hA1, 6'h02, 1'b0, 1'b1);
    cyc(1'b1, 32'hA2, 6'h03, 1'b1, 1'b1);
    idle(3, 1'b1);
    chk("framing_flag", 64'(framing_err), 64'd1);

    // Randomized traffic
    rdest = 6'($urandom_range(0, 63));
    for (int i = 0; i < 400; i++) begin
      logic s, t, r;
      logic [5:0] ds;
      s  = ($urandom_range(0, 99) < 60);
      t  = ($urandom_range(0, 99) < 30);
      r  = ($urandom_range(0, 99) < 70);
      ds = ($urandom_range(0, 19) == 0) ? 6'($urandom_range(0, 63)) : rdest;
      cyc(s, $urandom, ds, t, r);
      if (s && t) rdest = 6'($urandom_range(0, 63));
    end
    idle(DEPTH + 2, 1'b1);

    // Run packet counter up to 0xFFFF, then wrap
    while (32'(exp_pkt) + 32'(mq.size()) < 32'd65535)
      cyc(1'b1, $urandom, 6'h01, 1'b1, 1'b1);
    idle(3, 1'b1);
    chk("pkt_ffff", 64'(pkt_count), 64'hFFFF);
    cyc(1'b1, 32'h55, 6'h01, 1'b1, 1'b1);
    idle(2, 1'b1);
    chk("pkt_wrap", 64'(pkt_count), 64'h0);

    // Reset mid-packet with two flits buffered
    cyc(1'b1, 32'hB0, 6'h04, 1'b0, 1'b0);
    cyc(1'b1, 32'hB1, 6'h04, 1'b0, 1'b0);
    chk("prerst_occ", 64'(dut.occupancy), 64'd2);
    send_in = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    model_reset();
    repeat (2) @(posedge clk_noc);
    @(negedge clk_noc) rst_n = 1'b1;
    @(posedge clk_noc); #1;
    cyc(1'b1, 32'hC0FFEE, 6'h0A, 1'b1, 1'b1);
    idle(3, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
